// File: rtl/rule110_frame_rx.sv
// Reassembles MSW-first word streams into rows and checks each row against the Rule 110 successor of the previous row.
// Latency: last word accepted in cycle T -> row_valid/row_o/match in cycle T+2.
// Backpressure: none, always accepts; stray or restarting words raise a one-cycle frame_err.
module rule110_frame_rx #(
    parameter int WORD_W  = 16,
    parameter int N_WORDS = 16,
    localparam int ROW_W  = WORD_W * N_WORDS,
    localparam int IDX_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    input  logic              frame_start,
    output logic [ROW_W-1:0]  row_o,
    output logic              row_valid,
    output logic              match,
    output logic [15:0]       gen_cnt,
    output logic [7:0]        mismatch_cnt,
    output logic              frame_err
);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [ROW_W-1:0]   buffer;
    logic [ROW_W-1:0]   prev;
    logic               first;

    logic [ROW_W-1:0]   hi;
    logic [ROW_W-1:0]   lo;
    logic [ROW_W-1:0]   succ;
    logic               row_ok;

    // Neighbours shifted in with zeros at both row ends.
    assign hi     = prev >> 1;
    assign lo     = prev << 1;
    assign succ   = (prev & ~(hi & lo)) | (~prev & lo);
    assign row_ok = first || (buffer == succ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            buffer       <= '0;
            prev         <= '0;
            row_o        <= '0;
            row_valid    <= 1'b0;
            match        <= 1'b0;
            gen_cnt      <= '0;
            mismatch_cnt <= '0;
            frame_err    <= 1'b0;
            first        <= 1'b1;
        end else begin
            row_valid <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (word_valid) begin
                        if (frame_start) begin
                            buffer[ROW_W-1 -: WORD_W] <= word_in;
                            idx                       <= IDX_W'(1);
                            state                     <= RECV;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (word_valid) begin
                        if (frame_start) begin
                            // Restart: the new word becomes word 0 of a fresh frame.
                            frame_err                 <= 1'b1;
                            buffer[ROW_W-1 -: WORD_W] <= word_in;
                            idx                       <= IDX_W'(1);
                        end else begin
                            buffer[ROW_W-1-int'(idx)*WORD_W -: WORD_W] <= word_in;
                            if (idx == IDX_W'(N_WORDS-1)) begin
                                idx   <= '0;
                                state <= CHECK;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end
                    end
                end
                CHECK: begin
                    state     <= IDLE;
                    row_o     <= buffer;
                    prev      <= buffer;
                    row_valid <= 1'b1;
                    match     <= row_ok;
                    gen_cnt   <= gen_cnt + 16'd1;
                    first     <= 1'b0;
                    if (!row_ok && mismatch_cnt != 8'hFF)
                        mismatch_cnt <= mismatch_cnt + 8'd1;
                    if (word_valid && frame_start)
                        frame_err <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rule110_frame_rx.sv
// Directed bench for rule110_frame_rx: framing, Rule 110 matching, counters, errors, reset.
module tb_rule110_frame_rx;

    localparam int WORD_W  = 16;
    localparam int N_WORDS = 16;
    localparam int ROW_W   = WORD_W * N_WORDS;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              frame_start;
    logic [ROW_W-1:0]  row_o;
    logic              row_valid;
    logic              match;
    logic [15:0]       gen_cnt;
    logic [7:0]        mismatch_cnt;
    logic              frame_err;

    int n_cmp  = 0;
    int n_fail = 0;

    rule110_frame_rx #(.WORD_W(WORD_W), .N_WORDS(N_WORDS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .word_in      (word_in),
        .word_valid   (word_valid),
        .frame_start  (frame_start),
        .row_o        (row_o),
        .row_valid    (row_valid),
        .match        (match),
        .gen_cnt      (gen_cnt),
        .mismatch_cnt (mismatch_cnt),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic drive(input logic v, input logic fs, input logic [WORD_W-1:0] w);
        @(negedge clk);
        word_valid  = v;
        frame_start = fs;
        word_in     = w;
    endtask

    task automatic send_frame(input logic [ROW_W-1:0] row, input int max_gap, input string tag);
        for (int k = 0; k < N_WORDS; k++) begin
            int g;
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (g) drive(1'b0, 1'b0, '0);
            drive(1'b1, k == 0, row[ROW_W-1-WORD_W*k -: WORD_W]);
        end
        drive(1'b0, 1'b0, '0);
        chk({tag, " row_valid T+1"}, row_valid, 0);
        drive(1'b0, 1'b0, '0);
        chk({tag, " row_valid T+2"}, row_valid, 1);
        chk({tag, " row_o"}, row_o, row);
    endtask

    initial begin
        logic [ROW_W-1:0] junk;
        logic [ROW_W-1:0] r7;
        junk        = {16{16'hA5C3}};
        r7          = 256'h7;
        rst_n       = 1'b0;
        word_in     = '0;
        word_valid  = 1'b0;
        frame_start = 1'b0;

        #12;
        chk("rst row_o", row_o, 0);
        chk("rst row_valid", row_valid, 0);
        chk("rst match", match, 0);
        chk("rst gen_cnt", gen_cnt, 0);
        chk("rst mismatch_cnt", mismatch_cnt, 0);
        chk("rst frame_err", frame_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, '0);
        chk("post-rst row_valid", row_valid, 0);
        chk("post-rst gen_cnt", gen_cnt, 0);

        // First frame always matches.
        send_frame(256'h1, 0, "f1");
        chk("f1 match", match, 1);
        chk("f1 gen_cnt", gen_cnt, 1);
        chk("f1 mismatch_cnt", mismatch_cnt, 0);
        drive(1'b0, 1'b0, '0);
        chk("f1 row_valid pulse end", row_valid, 0);
        chk("f1 match held", match, 1);

        // Successor of 1 is 3; successor of 3 is 7, so a repeated 3 mismatches.
        send_frame(256'h3, 0, "f2");
        chk("f2 match", match, 1);
        chk("f2 mismatch_cnt", mismatch_cnt, 0);
        chk("f2 gen_cnt", gen_cnt, 2);
        send_frame(256'h3, 0, "f3");
        chk("f3 match", match, 0);
        chk("f3 mismatch_cnt", mismatch_cnt, 1);
        chk("f3 gen_cnt", gen_cnt, 3);

        // Gapped frame restarted at word 7; only the restarted frame counts.
        for (int k = 0; k < 7; k++) begin
            drive(1'b0, 1'b0, '0);
            drive(1'b1, k == 0, junk[ROW_W-1-WORD_W*k -: WORD_W]);
        end
        drive(1'b1, 1'b1, r7[ROW_W-1 -: WORD_W]);
        drive(1'b0, 1'b0, '0);
        chk("restart frame_err", frame_err, 1);
        drive(1'b0, 1'b0, '0);
        chk("restart frame_err end", frame_err, 0);
        chk("restart no row_valid", row_valid, 0);
        for (int k = 1; k < N_WORDS; k++) begin
            repeat ($urandom_range(0, 3)) drive(1'b0, 1'b0, '0);
            drive(1'b1, 1'b0, r7[ROW_W-1-WORD_W*k -: WORD_W]);
        end
        drive(1'b0, 1'b0, '0);
        chk("gap row_valid T+1", row_valid, 0);
        drive(1'b0, 1'b0, '0);
        chk("gap row_valid T+2", row_valid, 1);
        chk("gap row_o", row_o, r7);
        chk("gap match", match, 1);
        chk("gap gen_cnt", gen_cnt, 4);
        chk("gap mismatch_cnt", mismatch_cnt, 1);

        // Stray word in IDLE.
        drive(1'b1, 1'b0, 16'hBEEF);
        drive(1'b0, 1'b0, '0);
        chk("stray frame_err", frame_err, 1);
        chk("stray row_valid", row_valid, 0);
        drive(1'b0, 1'b0, '0);
        chk("stray frame_err end", frame_err, 0);
        chk("stray gen_cnt", gen_cnt, 4);

        // Row 1 never equals its own successor (3), nor the successor of 7.
        repeat (300) send_frame(256'h1, 0, "sat");
        chk("sat mismatch_cnt", mismatch_cnt, 8'hFF);
        chk("sat match", match, 0);
        chk("sat gen_cnt", gen_cnt, 304);

        // Preload gen_cnt to the top of its range.
        force dut.gen_cnt = 16'hFFFF;
        drive(1'b0, 1'b0, '0);
        release dut.gen_cnt;
        drive(1'b0, 1'b0, '0);
        chk("preload gen_cnt", gen_cnt, 16'hFFFF);
        send_frame(256'h1, 0, "wrap");
        chk("wrap gen_cnt", gen_cnt, 0);

        // Asynchronous reset while word 9 is on the bus.
        for (int k = 0; k < 9; k++)
            drive(1'b1, k == 0, junk[ROW_W-1-WORD_W*k -: WORD_W]);
        drive(1'b1, 1'b0, junk[ROW_W-1-WORD_W*9 -: WORD_W]);
        #2 rst_n = 1'b0;
        #1;
        chk("arst row_o", row_o, 0);
        chk("arst row_valid", row_valid, 0);
        chk("arst match", match, 0);
        chk("arst gen_cnt", gen_cnt, 0);
        chk("arst mismatch_cnt", mismatch_cnt, 0);
        chk("arst frame_err", frame_err, 0);
        drive(1'b0, 1'b0, '0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, '0);
        chk("arst no row_valid", row_valid, 0);
        chk("arst no frame_err", frame_err, 0);
        send_frame(256'h5, 0, "after_rst");
        chk("after_rst match", match, 1);
        chk("after_rst gen_cnt", gen_cnt, 1);
        chk("after_rst mismatch_cnt", mismatch_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rule110_frame_rx.md
RULE110_FRAME_RX -- requirements
Module: rule110_frame_rx

Interface
REQ-001 Parameter WORD_W, default 16, width of one stream word.
REQ-002 Parameter N_WORDS, default 16, words per frame; ROW_W = WORD_W*N_WORDS (256).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 word_in  in  WORD_W  stream word; word 0 = row bits [ROW_W-1 -: WORD_W], MSW first.
REQ-007 word_valid  in  1  word_in valid this cycle.
REQ-008 frame_start  in  1  marks word 0; qualified by word_valid.
REQ-009 row_o  out  ROW_W  last completed row.
REQ-010 row_valid  out  1  one-cycle pulse, new row_o/match valid.
REQ-011 match  out  1  row_o equals Rule 110 successor of previous row.
REQ-012 gen_cnt  out  16  completed frames, wraps at 16'hFFFF->0.
REQ-013 mismatch_cnt  out  8  frames with match=0, saturates at 8'hFF.
REQ-014 frame_err  out  1  one-cycle pulse on protocol error.

Function
REQ-015 FSM states SHALL be IDLE, RECV, CHECK; only words with word_valid=1 are accepted.
REQ-016 IDLE: word_valid&frame_start -> store word 0, word index=1, go RECV; word_valid without frame_start -> word dropped, frame_err pulse next cycle, stay IDLE.
REQ-017 RECV: word_valid=0 cycles (gaps) SHALL be allowed, index holds.
REQ-018 RECV: word_valid&~frame_start -> store word at index, index+1; on storing index N_WORDS-1, go CHECK.
REQ-019 RECV: word_valid&frame_start -> frame_err pulse next cycle, partial frame discarded, word stored as new word 0, index=1, stay RECV.
REQ-020 Assembly buffer SHALL be separate from row_o; row_o SHALL change only on frame completion.
REQ-021 CHECK lasts exactly one cycle, then IDLE; any word_valid in CHECK is dropped, and with frame_start also pulses frame_err.
REQ-022 Expected successor e of previous row p, per bit i: hi=p[i+1] (0 at i=ROW_W-1), lo=p[i-1] (0 at i=0), c=p[i]; e[i]=(c&~(hi&lo))|(~c&lo) (Rule 110, zero boundaries).
REQ-023 At edge ending CHECK: row_o<=buffer, prev<=buffer, row_valid<=1, match<=(first ? 1 : buffer==e), gen_cnt+1, mismatch_cnt+1 (saturating) iff match=0, first<=0.
REQ-024 Latency: last word accepted in cycle T -> row_valid=1 and new row_o/match visible in cycle T+2.
REQ-025 row_valid and frame_err SHALL be high for exactly one cycle per event; match holds until the next frame completes.
REQ-026 Minimum frame-to-frame spacing: the first word of the next frame SHALL be accepted in cycle T+2 or later.

Reset
REQ-027 rst_n=0 SHALL immediately force: state IDLE, index 0, buffer/prev/row_o=0, row_valid=0, match=0, gen_cnt=0, mismatch_cnt=0, frame_err=0, first=1.
REQ-028 Reset mid-frame SHALL discard the partial frame with no row_valid or frame_err pulse.
REQ-029 Outputs SHALL be stable and valid in the first cycle after rst_n deasserts.

Verification
REQ-030 Single frame: 16 back-to-back words, row=256'h1 -> row_valid 2 cycles after the last word, row_o=256'h1, match=1 (first), gen_cnt=1.
REQ-031 Legal successor: after row 256'h1, send row 256'h3 -> match=1, mismatch_cnt=0, gen_cnt=2; then send 256'h3 again -> match=0, mismatch_cnt=1.
REQ-032 Gaps: random word_valid=0 cycles between words -> same row_o as back-to-back; frame_start re-asserted at word 7 -> frame_err pulse, completed row built from the restarted frame only.
REQ-033 Stray words: word_valid without frame_start in IDLE -> frame_err pulse, gen_cnt unchanged, no row_valid.
REQ-034 Saturation/wrap: 300 mismatching frames -> mismatch_cnt=8'hFF; gen_cnt preloaded by 65535 frames -> next frame gives 0.
REQ-035 Async reset asserted during word 9 -> all outputs zero immediately; next full frame reports match=1 (first) and gen_cnt=1.
